// File: rtl/seven_seg_capture.sv
// Two-digit multiplexed 7-segment bus capture.
// Re-assembles frames, decodes hex digits, watches strobe gaps.
module seven_seg_capture #(
  parameter int CBITS   = 15,
  parameter int TIMEOUT = 17502
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  segment,
  input  logic        sig,
  output logic [13:0] both7seg,
  output logic [3:0]  hex_hi,
  output logic [3:0]  hex_lo,
  output logic        err_hi,
  output logic        err_lo,
  output logic        frame_valid,
  output logic        timeout
);

  localparam logic [0:0] WAIT_HI = 1'b0;
  localparam logic [0:0] WAIT_LO = 1'b1;

  localparam logic [CBITS-1:0] TMO = CBITS'(TIMEOUT);

  logic [0:0]       state;
  logic [6:0]       hold;
  logic [CBITS-1:0] gap;
  logic [CBITS-1:0] gap_nxt;
  logic             tmo_hit;
  logic [4:0]       dec_hi;
  logic [4:0]       dec_lo;

  // {err, nibble}; unknown patterns decode to 0 with err set
  function automatic logic [4:0] decode(
    input logic [6:0] p
  );
    logic [4:0] r;
    case (p)
      7'h3F:   r = 5'h00;
      7'h06:   r = 5'h01;
      7'h5B:   r = 5'h02;
      7'h4F:   r = 5'h03;
      7'h66:   r = 5'h04;
      7'h6D:   r = 5'h05;
      7'h7D:   r = 5'h06;
      7'h07:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h6F:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h7C:   r = 5'h0B;
      7'h39:   r = 5'h0C;
      7'h5E:   r = 5'h0D;
      7'h79:   r = 5'h0E;
      7'h71:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  assign dec_hi = decode(hold);
  assign dec_lo = decode(segment);

  // Watchdog next value; a strobe always beats the timeout
  always_comb begin
    gap_nxt = '0;
    tmo_hit = 1'b0;
    if (!sig) begin
      if (gap == TMO) begin
        gap_nxt = TMO;
      end else begin
        gap_nxt = gap + 1'b1;
      end
      tmo_hit = (gap_nxt == TMO);
    end
  end

  // Capture FSM, watchdog and published frame registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= WAIT_HI;
      hold        <= '0;
      gap         <= '0;
      both7seg    <= '0;
      hex_hi      <= '0;
      hex_lo      <= '0;
      err_hi      <= 1'b0;
      err_lo      <= 1'b0;
      frame_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      gap         <= gap_nxt;
      frame_valid <= 1'b0;
      if (sig) begin
        timeout <= 1'b0;
      end else if (tmo_hit) begin
        timeout <= 1'b1;
      end
      if (tmo_hit) begin
        state <= WAIT_HI;
        hold  <= '0;
      end else if (sig) begin
        case (state)
          WAIT_HI: begin
            hold  <= segment;
            state <= WAIT_LO;
          end
          default: begin
            both7seg    <= {hold, segment};
            hex_hi      <= dec_hi[3:0];
            err_hi      <= dec_hi[4];
            hex_lo      <= dec_lo[3:0];
            err_lo      <= dec_lo[4];
            frame_valid <= 1'b1;
            state       <= WAIT_HI;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture.
// Directed scenarios plus random traffic against a frame-level model.
module tb_seven_seg_capture;

  localparam int TIMEOUT = 17502;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  segment = '0;
  logic        sig = 1'b0;
  logic [13:0] both7seg;
  logic [3:0]  hex_hi;
  logic [3:0]  hex_lo;
  logic        err_hi;
  logic        err_lo;
  logic        frame_valid;
  logic        timeout;

  seven_seg_capture #(
    .CBITS(15),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .segment(segment),
    .sig(sig),
    .both7seg(both7seg),
    .hex_hi(hex_hi),
    .hex_lo(hex_lo),
    .err_hi(err_hi),
    .err_lo(err_lo),
    .frame_valid(frame_valid),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [6:0] tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // model state
  int         m_gap;
  bit         m_tmo;
  bit         m_have_hi;
  logic [6:0] m_held;
  logic [13:0] m_both;
  logic [3:0] m_hh;
  logic [3:0] m_hl;
  bit         m_eh;
  bit         m_el;
  bit         m_fv;

  task automatic lookup(input logic [6:0] p,
                        output logic [3:0] n,
                        output bit e);
    n = 4'h0;
    e = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (tbl[i] == p) begin
        n = 4'(i);
        e = 1'b0;
      end
    end
  endtask

  task automatic model(input bit r, input bit s,
                       input logic [6:0] p);
    if (r) begin
      m_gap = 0; m_tmo = 0; m_have_hi = 0; m_held = '0;
      m_both = '0; m_hh = '0; m_hl = '0;
      m_eh = 0; m_el = 0; m_fv = 0;
    end else begin
      m_fv = 0;
      if (s) begin
        m_gap = 0;
        m_tmo = 0;
        if (!m_have_hi) begin
          m_held = p;
          m_have_hi = 1;
        end else begin
          m_both = {m_held, p};
          lookup(m_held, m_hh, m_eh);
          lookup(p, m_hl, m_el);
          m_fv = 1;
          m_have_hi = 0;
        end
      end else begin
        if (m_gap < TIMEOUT) m_gap++;
        if (m_gap == TIMEOUT) begin
          m_tmo = 1;
          m_have_hi = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("both7seg", 32'(both7seg), 32'(m_both));
    chk("hex_hi", 32'(hex_hi), 32'(m_hh));
    chk("hex_lo", 32'(hex_lo), 32'(m_hl));
    chk("err_hi", 32'(err_hi), 32'(m_eh));
    chk("err_lo", 32'(err_lo), 32'(m_el));
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("timeout", 32'(timeout), 32'(m_tmo));
  endtask

  task automatic cyc(input bit r, input bit s,
                     input logic [6:0] p);
    rst = r;
    sig = s;
    segment = p;
    @(posedge clk);
    model(r, s, p);
    #1;
    chk_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 7'(i));
  endtask

  initial begin
    // 1: reset, then two strobes 17501 cycles apart
    cyc(1, 0, 7'h00);
    cyc(1, 1, 7'h06);
    chk("rst_both", 32'(both7seg), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    cyc(0, 1, 7'h06);
    idle(17500);
    chk("t1_no_tmo", 32'(timeout), 32'h0);
    cyc(0, 1, 7'h5B);
    chk("t1_both", 32'(both7seg), 32'h035B);
    chk("t1_hex", 32'({hex_hi, hex_lo}), 32'h12);
    chk("t1_err", 32'({err_hi, err_lo}), 32'h0);
    chk("t1_fv", 32'(frame_valid), 32'h1);
    idle(1);
    chk("t1_fv_drop", 32'(frame_valid), 32'h0);

    // 2: back-to-back frames
    cyc(0, 1, 7'h7F);
    cyc(0, 1, 7'h6F);
    chk("t2_f1", 32'(both7seg), 32'h3FEF);
    chk("t2_h1", 32'({hex_hi, hex_lo}), 32'h89);
    cyc(0, 1, 7'h77);
    chk("t2_fv_gap", 32'(frame_valid), 32'h0);
    cyc(0, 1, 7'h71);
    chk("t2_f2", 32'(both7seg), 32'h3BF1);
    chk("t2_h2", 32'({hex_hi, hex_lo}), 32'hAF);
    chk("t2_fv2", 32'(frame_valid), 32'h1);

    // 3: undecodable high digit
    cyc(0, 1, 7'h00);
    cyc(0, 1, 7'h3F);
    chk("t3_both", 32'(both7seg), 32'h003F);
    chk("t3_err", 32'({err_hi, err_lo}), 32'h2);
    chk("t3_hexhi", 32'(hex_hi), 32'h0);

    // 4: timeout discards held high digit
    cyc(0, 1, 7'h06);
    idle(TIMEOUT - 1);
    chk("t4_pre", 32'(timeout), 32'h0);
    idle(1);
    chk("t4_tmo", 32'(timeout), 32'h1);
    chk("t4_hold_out", 32'(both7seg), 32'h003F);
    idle(3);
    chk("t4_sticky", 32'(timeout), 32'h1);
    cyc(0, 1, 7'h4F);
    chk("t4_clr", 32'(timeout), 32'h0);
    chk("t4_nofv", 32'(frame_valid), 32'h0);
    cyc(0, 1, 7'h66);
    chk("t4_both", 32'(both7seg), 32'h27E6);
    chk("t4_hex", 32'({hex_hi, hex_lo}), 32'h34);

    // 5: strobe at gap TIMEOUT-1 keeps phase
    cyc(0, 1, 7'h3F);
    idle(TIMEOUT - 1);
    cyc(0, 1, 7'h06);
    chk("t5_tmo", 32'(timeout), 32'h0);
    chk("t5_both", 32'(both7seg), 32'h1F86);
    chk("t5_fv", 32'(frame_valid), 32'h1);

    // 6: reset mid-frame with sig
    cyc(0, 1, 7'h06);
    cyc(1, 1, 7'h5B);
    chk("t6_both", 32'(both7seg), 32'h0);
    chk("t6_hex", 32'({hex_hi, hex_lo}), 32'h0);
    cyc(0, 1, 7'h66);
    chk("t6_nofv", 32'(frame_valid), 32'h0);
    cyc(0, 1, 7'h6D);
    chk("t6_both2", 32'(both7seg), 32'h336D);
    chk("t6_hex2", 32'({hex_hi, hex_lo}), 32'h45);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      bit r;
      bit s;
      logic [6:0] p;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) p = 7'($urandom);
      else p = tbl[$urandom_range(0, 15)];
      cyc(r, s, p);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
